// File: rtl/state_word_reader.sv
// Snapshots a 320-bit ASCON state on start_i and streams a clamped, contiguous
// run of its 64-bit words (x0..x4) out over a valid/ready handshake.
module state_word_reader #(
  parameter int WORD_W   = 64,
  parameter int NB_WORDS = 5
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [2:0]                 first_i,
  input  logic [2:0]                 count_i,
  input  logic [NB_WORDS*WORD_W-1:0] state_i,
  input  logic                       ready_i,
  output logic [WORD_W-1:0]          word_o,
  output logic [2:0]                 index_o,
  output logic                       valid_o,
  output logic                       busy_o,
  output logic                       done_o
);

  // Handshake: a word transfers on every rising edge where valid_o and ready_i
  // are both high; while ready_i is low, word_o/index_o/valid_o hold unchanged.

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [2:0] NB3      = 3'(NB_WORDS);
  localparam logic [2:0] LAST_IDX = 3'(NB_WORDS - 1);

  state_t            state_q;
  logic [WORD_W-1:0] snap_q   [NB_WORDS];
  logic [WORD_W-1:0] in_words [NB_WORDS];
  logic [2:0]        rem_q;
  logic [2:0]        avail;
  logic [2:0]        eff_count;

  always_comb begin
    for (int i = 0; i < NB_WORDS; i++) begin
      in_words[i] = state_i[i*WORD_W +: WORD_W];
    end
    avail     = (first_i > LAST_IDX) ? 3'd0 : (NB3 - first_i);
    eff_count = (count_i < avail) ? count_i : avail;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      for (int i = 0; i < NB_WORDS; i++) begin
        snap_q[i] <= '0;
      end
      rem_q   <= 3'd0;
      word_o  <= '0;
      index_o <= 3'd0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_o <= 1'b0;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          if (start_i) begin
            for (int i = 0; i < NB_WORDS; i++) begin
              snap_q[i] <= in_words[i];
            end
            busy_o <= 1'b1;
            if (eff_count == 3'd0) begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end else begin
              // First word comes straight from the input so valid_o can rise next cycle.
              state_q <= SEND;
              word_o  <= in_words[first_i];
              index_o <= first_i;
              rem_q   <= eff_count;
              valid_o <= 1'b1;
            end
          end
        end
        SEND: begin
          if (ready_i) begin
            if (rem_q > 3'd1) begin
              index_o <= index_o + 3'd1;
              word_o  <= snap_q[index_o + 3'd1];
              rem_q   <= rem_q - 3'd1;
            end else begin
              state_q <= DONE;
              valid_o <= 1'b0;
              done_o  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_o <= 1'b0;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
